// File: rtl/arbitro_pkg.sv
// rtl/arbitro_pkg.sv - shared types and grant encodings for the two-way peripheral arbiter
package arbitro_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    ACK   = 2'd2,
    DRAIN = 2'd3
  } estado_t;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_A    = 2'b01;
  localparam logic [1:0] GNT_B    = 2'b10;

  // prio=0 favours A, prio=1 favours B when both are eligible.
  function automatic logic [1:0] pick_winner(input logic elig_a, input logic elig_b,
                                             input logic prio);
    logic [1:0] w;
    w = GNT_NONE;
    if (elig_a && elig_b) w = prio ? GNT_B : GNT_A;
    else if (elig_a)      w = GNT_A;
    else if (elig_b)      w = GNT_B;
    return w;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for a single asynchronous level
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/arbitro_periferico.sv
// rtl/arbitro_periferico.sv - round-robin arbiter sharing one send/ack peripheral between two requesters
module arbitro_periferico
  import arbitro_pkg::*;
#(
  parameter int DATA_W  = 4,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sendA,
  input  logic [DATA_W-1:0] dadosA,
  output logic              ackA,
  input  logic              sendB,
  input  logic [DATA_W-1:0] dadosB,
  output logic              ackB,
  output logic              send_out,
  output logic [DATA_W-1:0] dados_out,
  input  logic              ack_in,
  output logic [1:0]        grant,
  output logic [1:0]        estado,
  output logic              timeout_err,
  output logic [7:0]        xfer_cnt
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  estado_t             state, state_d;
  logic [7:0]          cnt, cnt_d;
  logic                prio, prio_d;
  logic                ack_s;
  logic [1:0]          winner;
  logic                granted_send;
  logic [1:0]          grant_d;
  logic                send_d;
  logic [DATA_W-1:0]   dados_d;
  logic                acka_d, ackb_d;
  logic                terr_d;
  logic [7:0]          xcnt_d;

  sync_2ff u_sync_ack (
    .clk   (clk),
    .rst_n (rst),
    .d     (ack_in),
    .q     (ack_s)
  );

  assign winner       = pick_winner(sendA & ~ackA, sendB & ~ackB, prio);
  assign granted_send = (grant == GNT_B) ? sendB : sendA;
  assign estado       = state;

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    prio_d  = prio;
    grant_d = grant;
    send_d  = send_out;
    dados_d = dados_out;
    acka_d  = ackA;
    ackb_d  = ackB;
    terr_d  = 1'b0;
    xcnt_d  = xfer_cnt;

    case (state)
      IDLE: begin
        // A lingering ack from the previous transfer blocks new grants.
        if (!ack_s && winner != GNT_NONE) begin
          state_d = REQ;
          grant_d = winner;
          send_d  = 1'b1;
          dados_d = (winner == GNT_B) ? dadosB : dadosA;
          cnt_d   = 8'd0;
        end
      end

      REQ: begin
        cnt_d = cnt + 8'd1;
        if (ack_s) begin
          state_d = ACK;
          send_d  = 1'b0;
          acka_d  = (grant == GNT_A);
          ackb_d  = (grant == GNT_B);
        end else if (cnt == CNT_LAST) begin
          state_d = DRAIN;
          send_d  = 1'b0;
          terr_d  = 1'b1;
        end
      end

      ACK: begin
        if (!granted_send && !ack_s) begin
          state_d = IDLE;
          acka_d  = 1'b0;
          ackb_d  = 1'b0;
          grant_d = GNT_NONE;
          prio_d  = (grant == GNT_A);
          xcnt_d  = xfer_cnt + 8'd1;
        end
      end

      DRAIN: begin
        // Aborted requester keeps send high and competes again from IDLE.
        if (!ack_s) begin
          state_d = IDLE;
          grant_d = GNT_NONE;
          prio_d  = (grant == GNT_A);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= 8'd0;
      prio        <= 1'b0;
      grant       <= GNT_NONE;
      send_out    <= 1'b0;
      dados_out   <= '0;
      ackA        <= 1'b0;
      ackB        <= 1'b0;
      timeout_err <= 1'b0;
      xfer_cnt    <= 8'd0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      prio        <= prio_d;
      grant       <= grant_d;
      send_out    <= send_d;
      dados_out   <= dados_d;
      ackA        <= acka_d;
      ackB        <= ackb_d;
      timeout_err <= terr_d;
      xfer_cnt    <= xcnt_d;
    end
  end

endmodule
